mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Serialises accesses and drives the pipeline-wide stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
//  Data accesses have priority; a streak counter guarantees the fetch port is eventually served.
// PARAMETERS
//  AW               32   address width
//  DW               32   data width
//  MAX_DATA_STREAK  4    max consecutive data grants while a fetch waits (>=1)
//  TIMEOUT_CYC      64   cycles in BUSY without mem_ack_i before abort (>=2)
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_i        in   1   reset: asynchronous, active-low
//  if_req_i     in   1   fetch request; held until if_ready_o
//  if_addr_i    in   AW  fetch address (PC)
//  if_flush_i   in   1   wrong-path fetch: discard in-flight fetch result
//  if_rdata_o   out  DW  fetched instruction, valid with if_ready_o
//  if_ready_o   out  1   1-cycle completion pulse, fetch port
//  dm_req_i     in   1   data request; held until dm_ready_o
//  dm_we_i      in   1   1=store, 0=load
//  dm_addr_i    in   AW  data address (EX_MEM ALU result)
//  dm_wdata_i   in   DW  store data
//  dm_rdata_o   out  DW  load data, valid with dm_ready_o
//  dm_ready_o   out  1   1-cycle completion pulse, data port
//  mem_req_o    out  1   request to memory; held until mem_ack_i
//  mem_we_o     out  1   write enable to memory
//  mem_addr_o   out  AW  memory address
//  mem_wdata_o  out  DW  memory write data
//  mem_ack_i    in   1   memory completion; mem_rdata_i valid same cycle
//  mem_rdata_i  in   DW  memory read data
//  stall_o      out  1   (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o)
//  err_o        out  1   sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (rdata 0, streak 0, err_o 0); stall_o follows requests combinationally.
//  - FSM IDLE -> BUSY -> RESP -> IDLE; one access in flight max.
//  - IDLE, grant decision:
//    - dm_req_i wins, unless if_req_i=1 and streak==MAX_DATA_STREAK, in which case IF wins.
//    - Register owner, addr, we (0 for IF) and wdata; go BUSY.
//    - No request: stay in IDLE.
//  - BUSY: mem_req_o=1 with registered fields, stable until ack.
//    - On mem_ack_i: latch mem_rdata_i into the owner's rdata register; go RESP.
//  - RESP: mem_req_o=0; pulse owner's ready_o for exactly 1 cycle; go IDLE.
//  - Latency: request seen in cycle 0, ack in cycle 1 at the earliest, ready in cycle 2.
//    Minimum 3 cycles per access; back-to-back grants every 3 cycles.
//  - Streak counter:
//    - Increments on a data grant while if_req_i=1, saturating at MAX_DATA_STREAK.
//    - Clears on any IF grant, or on a data grant with if_req_i=0.
//  - Stores: dm_rdata_o is still updated with mem_rdata_i (don't-care content); dm_ready_o pulses normally.
//  - Flush: if_flush_i=1 while IF owns BUSY or RESP sets a discard flag.
//    - The memory access still completes; if_ready_o and the if_rdata_o update are suppressed.
//    - Flag clears on entry to IDLE. Flush in IDLE has no effect.
//  - Flush suppression holds stall_o via if_req_i until the re-fetch completes.
//  - Timeout: counter runs in BUSY. At TIMEOUT_CYC cycles without ack:
//    - Set err_o, drop mem_req_o, go RESP.
//    - Owner's rdata = 32'hDEAD_BEEF; ready still pulses so the pipeline does not hang.
//  - An ack outside BUSY is ignored.
//  - A request dropped before ready is a protocol violation; the access completes and ready pulses anyway.
//  - Async reset mid-access: return to IDLE immediately, mem_req_o deasserts asynchronously.
//    No ready pulse is issued for the aborted access.
// STRUCTURE
//  - Package cpu_mem_pkg: state enum {IDLE, BUSY, RESP}, owner enum {OWN_IF, OWN_DM}, MEM_ERR_DATA=32'hDEAD_BEEF.
//  - Sub-module arb_streak_ctr: saturating streak counter, outputs force_if.
//  - Timeout counter, FSM and datapath registers stay in the top.
// TESTING
//  1. Single fetch: if_req_i=1, addr 0x40, ack 1 cycle after mem_req_o with rdata 0x8C010004
//     -> if_rdata_o=0x8C010004, if_ready_o high for 1 cycle, mem_we_o=0 throughout.
//  2. Simultaneous if_req_i and dm_req_i (store 0x1234 @0x100) -> data served first with mem_we_o=1,
//     mem_wdata_o=0x1234; fetch granted in the IDLE after RESP; stall_o high until if_ready_o.
//  3. dm_req_i held for 6 accesses with if_req_i=1, MAX_DATA_STREAK=4
//     -> grant order D,D,D,D,I,D,...; streak returns to 0 after the IF grant.
//  4. if_flush_i pulsed during an IF BUSY with ack after 3 cycles
//     -> mem_ack_i consumed, no if_ready_o, if_rdata_o unchanged; next fetch proceeds normally.
//  5. No ack for TIMEOUT_CYC=8 -> mem_req_o falls after 8 BUSY cycles, err_o=1 sticky,
//     owner rdata=0xDEADBEEF, ready pulses once.
//  6. rst_i low mid-BUSY -> mem_req_o and all outputs 0 without clock edge; after release, IDLE, no stale ready.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// FSM states, port ownership and the bus-error fill pattern.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts consecutive data grants made while a fetch waits.
// Raises force_if once the streak reaches MAX.
module arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant_dm_i,
  input  logic grant_if_i,
  input  logic if_req_i,
  output logic force_if_o
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (grant_if_i) begin
      r_cnt <= '0;
    end else if (grant_dm_i) begin
      if (!if_req_i)
        r_cnt <= '0;
      else if (r_cnt != CW'(MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_if_o = (r_cnt == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage accesses onto one memory port.
// Data wins by default; the streak counter bounds fetch starvation.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stall_o,
  output logic          err_o
);

  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t        r_state;
  state_t        w_next;
  owner_t        r_owner;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_discard;
  logic          r_err;
  logic [TW-1:0] r_tcnt;

  logic          w_idle;
  logic          w_busy;
  logic          w_resp;
  logic          w_force_if;
  logic          w_grant_dm;
  logic          w_grant_if;
  logic          w_timeout;
  logic          w_discard;
  logic          w_rd_upd;
  logic [DW-1:0] w_rd_val;

  assign w_idle = (r_state == IDLE);
  assign w_busy = (r_state == BUSY);
  assign w_resp = (r_state == RESP);

  assign w_grant_dm = w_idle & dm_req_i &
                      ~(if_req_i & w_force_if);
  assign w_grant_if = w_idle & if_req_i & ~w_grant_dm;

  assign w_timeout = w_busy & ~mem_ack_i &
                     (r_tcnt == TW'(TIMEOUT_CYC - 1));

  // A flush in the response cycle itself still kills the pulse.
  assign w_discard = r_discard | if_flush_i;

  assign w_rd_upd = w_busy & (mem_ack_i | w_timeout);
  assign w_rd_val = mem_ack_i ? mem_rdata_i
                              : DW'(MEM_ERR_DATA);

  arb_streak_ctr #(
    .MAX (MAX_DATA_STREAK)
  ) u_streak (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .grant_dm_i (w_grant_dm),
    .grant_if_i (w_grant_if),
    .if_req_i   (if_req_i),
    .force_if_o (w_force_if)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_grant_dm | w_grant_if) w_next = BUSY;
      BUSY: if (mem_ack_i | w_timeout)  w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    if_ready_o = 1'b0;
    dm_ready_o = 1'b0;
    unique case (1'b1)
      w_busy: begin
        mem_req_o = 1'b1;
        mem_we_o  = r_we;
      end
      w_resp: begin
        if_ready_o = (r_owner == OWN_IF) & ~w_discard;
        dm_ready_o = (r_owner == OWN_DM);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_owner    <= OWN_IF;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_discard  <= 1'b0;
      r_err      <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      if (w_grant_dm | w_grant_if) begin
        r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
        r_addr  <= w_grant_dm ? dm_addr_i : if_addr_i;
        r_we    <= w_grant_dm & dm_we_i;
        r_wdata <= w_grant_dm ? dm_wdata_i : '0;
        r_tcnt  <= '0;
      end
      if (w_busy & ~mem_ack_i & ~w_timeout)
        r_tcnt <= r_tcnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
      if (w_rd_upd) begin
        if (r_owner == OWN_DM)
          r_dm_rdata <= w_rd_val;
        else if (!w_discard)
          r_if_rdata <= w_rd_val;
      end
      if (w_resp)
        r_discard <= 1'b0;
      else if (w_busy & (r_owner == OWN_IF) & if_flush_i)
        r_discard <= 1'b1;
    end
  end

  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign err_o       = r_err;
  assign stall_o     = (if_req_i & ~if_ready_o) |
                       (dm_req_i & ~dm_ready_o);

endmodule
